ip_spi_seq: RTL and testbench
=============================

// Module: ip_spi_seq
// PURPOSE
//  Command sequencer directly upstream of the SPI master (ip_spi_m).
//  Host writes a list of {cmd, data, fm} entries into an internal FIFO and issues seq_start.
//  The block launches one SPI frame per entry: it holds spi_fire high until spi_done, then waits a programmable gap.
//  It repeats until the FIFO is empty, then pulses seq_done. Includes a done-watchdog and sticky error flags.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of 2 only.
//  PTR_W   3   log2(DEPTH).
//  TOUT_W  10  watchdog width; timeout after 2^TOUT_W-1 cycles in FIRE without spi_done.
// PORTS
//  clk          in   1      system clock.
//  rst_n        in   1      asynchronous active-low reset.
//  wr_en        in   1      push {wr_cmd, wr_data, wr_fm} into FIFO.
//  wr_cmd       in   4      SPI command nibble.
//  wr_data      in   12     SPI data.
//  wr_fm        in   2      data format: 0=8b, 1=10b, 2=12b.
//  seq_start    in   1      1-cycle pulse; start draining FIFO.
//  seq_abort    in   1      1-cycle pulse; stop after current frame and flush FIFO.
//  err_clr      in   1      clears ovf_err and tout_err.
//  reg_gap      in   8      idle cycles between frames; effective gap = max(reg_gap,4).
//  spi_done     in   1      end-of-frame from ip_spi_m.
//  spi_fire     out  1      level fire to ip_spi_m; registered.
//  spi_cmd      out  4      held stable from POP until the next POP.
//  spi_data     out  12     held stable from POP until the next POP.
//  spi_data_fm  out  2      held stable from POP until the next POP.
//  fifo_cnt     out  PTR_W+1  entries stored.
//  fifo_full    out  1      FIFO full.
//  fifo_empty   out  1      FIFO empty.
//  seq_busy     out  1      state != IDLE.
//  seq_done     out  1      1-cycle pulse at end of sequence (normal, abort or timeout).
//  ovf_err      out  1      sticky: write attempted while full.
//  tout_err     out  1      sticky: watchdog expired.
// BEHAVIOUR
//  Reset values:
//   - spi_fire, spi_cmd, spi_data, spi_data_fm = 0.
//   - fifo_cnt = 0, fifo_full = 0, fifo_empty = 1.
//   - seq_busy, seq_done, ovf_err, tout_err = 0.
//   - FSM = IDLE.
//  FIFO:
//   - Write while full is dropped and sets ovf_err, even if a pop occurs in the same cycle.
//   - Simultaneous write and pop when not full leaves fifo_cnt unchanged.
//   - Pointers wrap modulo DEPTH.
//  FSM states: IDLE, POP, FIRE, GAP, DONE.
//   - IDLE: seq_start with FIFO non-empty -> POP. seq_start with FIFO empty -> DONE. spi_done is ignored.
//   - POP (1 cycle): head entry registered onto spi_cmd/spi_data/spi_data_fm; rd_ptr advances; -> FIRE.
//     spi_fire is set on entry to FIRE: seq_start at cycle t gives spi_fire=1 at t+2.
//   - FIRE: spi_fire=1 and the watchdog counts.
//     On spi_done -> GAP, and spi_fire=0 in the following cycle.
//     If the watchdog reaches 2^TOUT_W-1 -> set tout_err, spi_fire=0, flush FIFO, -> DONE.
//   - GAP: counts max(reg_gap,4) cycles with spi_fire=0.
//     The minimum of 4 covers ip_spi_m's 2-flop synchroniser plus edge detector.
//     At terminal count: FIFO non-empty -> POP, else -> DONE. reg_gap is sampled on GAP entry.
//   - DONE: seq_done=1 for one cycle -> IDLE.
//  Abort:
//   - seq_abort in FIFO-non-empty POP/GAP/IDLE-busy states: flush FIFO -> DONE.
//   - seq_abort in FIRE: set abort flag. The frame completes normally on spi_done (never cut mid-frame). Then flush -> DONE; no GAP.
//   - seq_abort in IDLE is ignored.
//  Simultaneous events:
//   - seq_start while busy is ignored.
//   - wr_en while busy is accepted; new entries are drained in the same sequence.
//   - err_clr and a new error in the same cycle: the set wins.
//   - spi_done and watchdog expiry in the same cycle: spi_done wins, no tout_err.
//  Reset mid-operation: everything returns to reset values at once; the FIFO is emptied; spi_fire drops asynchronously.
// STRUCTURE
//  ip_spi_seq_def.vh holds shared constants:
//   - FSM one-hot localparams.
//   - ENT_W = 18 and entry field offsets.
//   - GAP_MIN = 4.
//  Sub-module ip_spi_seq_fifo: synchronous FIFO, DEPTH x ENT_W, with cnt/full/empty outputs.
//  Top level holds the FSM, gap counter, watchdog and error flags.
// TESTING
//  1. Push 3 entries (cmd 1/2/3, data 0x0AB/0x155/0xFFF, fm 0/1/2), reg_gap=10, start, with a master model.
//     -> 3 fire pulses in order; low gap of 10 cycles; one seq_done; fifo_empty=1.
//  2. reg_gap=0, 2 entries -> spi_fire stays low for exactly 4 cycles between frames.
//  3. Write 9 entries with DEPTH=8 -> fifo_cnt=8, fifo_full=1, ovf_err=1, 9th entry never sent; err_clr -> ovf_err=0.
//  4. Master model never returns spi_done, TOUT_W=6 -> tout_err=1 and spi_fire=0 63 cycles after spi_fire rises.
//     Remaining FIFO flushed; seq_done pulses.
//  5. 3 entries, seq_abort during frame 1 -> frame 1 completes; no further fire; fifo_cnt=0; seq_done 1 cycle after spi_done.
//  6. seq_start with FIFO empty -> seq_done at t+2, spi_fire never asserted.
//     Also: rst_n low mid-FIRE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ip_spi_seq_pkg.sv
// ---------------------------------------------------------------------------
// ip_spi_seq_pkg
// Shared types and constants for the SPI command sequencer:
//   entry_t  - one FIFO entry {cmd, data, fm}
//   state_e  - one-hot sequencer FSM encoding
//   GAP_MIN  - smallest inter-frame gap the SPI master can tolerate
//   eff_gap  - applies the GAP_MIN floor to the programmed gap
// ---------------------------------------------------------------------------
package ip_spi_seq_pkg;

  localparam logic [7:0] GAP_MIN = 8'd4;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] data;
    logic [1:0]  fm;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_POP  = 5'b00010,
    ST_FIRE = 5'b00100,
    ST_GAP  = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

  // The master resynchronises spi_fire through two flops plus an edge
  // detector, so fire must stay low for at least GAP_MIN cycles.
  function automatic logic [7:0] eff_gap(input logic [7:0] reg_gap);
    return (reg_gap < GAP_MIN) ? GAP_MIN : reg_gap;
  endfunction

endpackage

// File: rtl/ip_spi_seq_if.sv
// ---------------------------------------------------------------------------
// ip_spi_seq_if
// Frame handshake between the sequencer (master modport) and ip_spi_m
// (slave modport).
//   fire     - level request, held for the whole frame
//   cmd      - command nibble of the current frame
//   data     - payload of the current frame
//   data_fm  - payload format (0=8b, 1=10b, 2=12b)
//   done     - end-of-frame strobe from ip_spi_m
// ---------------------------------------------------------------------------
interface ip_spi_seq_if;
  logic        fire;
  logic [3:0]  cmd;
  logic [11:0] data;
  logic [1:0]  data_fm;
  logic        done;

  modport master (output fire, cmd, data, data_fm, input done);
  modport slave  (input fire, cmd, data, data_fm, output done);
endinterface

// File: rtl/ip_spi_seq_fifo.sv
// ---------------------------------------------------------------------------
// ip_spi_seq_fifo
// Synchronous DEPTH x ENT_W FIFO with first-word fall-through read data.
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr_en       - push wr_data (ignored when full or flushing)
//   wr_data     - entry to push
//   rd_en       - pop head (ignored when empty or flushing)
//   flush       - empty the FIFO; wins over push and pop
//   rd_data     - current head entry
//   cnt         - number of stored entries
//   full, empty - occupancy flags
// ---------------------------------------------------------------------------
module ip_spi_seq_fifo
  import ip_spi_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  entry_t       wr_data,
  input  logic         rd_en,
  input  logic         flush,
  output entry_t       rd_data,
  output logic [PTR_W:0] cnt,
  output logic         full,
  output logic         empty
);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = entry_t'(mem[rd_ptr]);

  // NOTE: the storage array has no reset; cnt/pointers alone define validity,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ip_spi_seq.sv
// ---------------------------------------------------------------------------
// ip_spi_seq
// Command sequencer feeding ip_spi_m: drains a FIFO of {cmd, data, fm}
// entries, one SPI frame per entry, with a programmable gap between frames,
// a done-watchdog and sticky error flags.
//   clk, rst_n              - clock, asynchronous active-low reset
//   wr_en/wr_cmd/wr_data/wr_fm - host push into the entry FIFO
//   seq_start, seq_abort    - 1-cycle control pulses
//   err_clr                 - clears ovf_err and tout_err
//   reg_gap                 - idle cycles between frames (floor of 4)
//   spi                     - frame handshake to ip_spi_m
//   fifo_cnt/full/empty     - FIFO status
//   seq_busy, seq_done      - sequence status / end-of-sequence pulse
//   ovf_err, tout_err       - sticky overflow and watchdog errors
// ---------------------------------------------------------------------------
module ip_spi_seq
  import ip_spi_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int TOUT_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [3:0]     wr_cmd,
  input  logic [11:0]    wr_data,
  input  logic [1:0]     wr_fm,
  input  logic           seq_start,
  input  logic           seq_abort,
  input  logic           err_clr,
  input  logic [7:0]     reg_gap,
  ip_spi_seq_if.master   spi,
  output logic [PTR_W:0] fifo_cnt,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic           seq_busy,
  output logic           seq_done,
  output logic           ovf_err,
  output logic           tout_err
);

  // wd_cnt is 0 in the first FIRE cycle, so this value marks the
  // (2^TOUT_W-1)-th FIRE cycle without spi_done.
  localparam logic [TOUT_W-1:0] WD_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};

  state_e            state;
  logic [TOUT_W-1:0] wd_cnt;
  logic [7:0]        gap_cnt;
  logic              abort_pend;
  entry_t            head;
  logic              pop;
  logic              flush;
  logic              wd_expire;

  ip_spi_seq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data ('{cmd: wr_cmd, data: wr_data, fm: wr_fm}),
    .rd_en   (pop),
    .flush   (flush),
    .rd_data (head),
    .cnt     (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign seq_busy  = (state != ST_IDLE);
  assign pop       = (state == ST_POP) && !seq_abort;
  // spi_done in the expiry cycle wins over the watchdog.
  assign wd_expire = (state == ST_FIRE) && !spi.done && (wd_cnt == WD_LAST);

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    flush = 1'b0;
    case (state)
      ST_POP, ST_GAP: flush = seq_abort;
      ST_FIRE:        flush = (spi.done && (abort_pend || seq_abort)) || wd_expire;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      spi.fire    <= 1'b0;
      spi.cmd     <= '0;
      spi.data    <= '0;
      spi.data_fm <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      abort_pend  <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (seq_start) state <= fifo_empty ? ST_DONE : ST_POP;
        end
        ST_POP: begin
          if (seq_abort) begin
            state <= ST_DONE;
          end else begin
            spi.cmd     <= head.cmd;
            spi.data    <= head.data;
            spi.data_fm <= head.fm;
            spi.fire    <= 1'b1;
            wd_cnt      <= '0;
            state       <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          // An abort never cuts a frame short; it is remembered until done.
          if (seq_abort) abort_pend <= 1'b1;
          if (spi.done) begin
            spi.fire <= 1'b0;
            if (abort_pend || seq_abort) begin
              state <= ST_DONE;
            end else begin
              // GAP lasts gap-1 cycles; the POP cycle completes the low time.
              gap_cnt <= eff_gap(reg_gap) - 8'd1;
              state   <= ST_GAP;
            end
          end else if (wd_expire) begin
            spi.fire <= 1'b0;
            state    <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (seq_abort)          state <= ST_DONE;
          else if (gap_cnt == 8'd1) state <= fifo_empty ? ST_DONE : ST_POP;
          else                    gap_cnt <= gap_cnt - 8'd1;
        end
        ST_DONE: begin
          seq_done   <= 1'b1;
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky errors: a new error in the same cycle as err_clr stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err  <= 1'b0;
      tout_err <= 1'b0;
    end else begin
      if (wr_en && fifo_full) ovf_err <= 1'b1;
      else if (err_clr)       ovf_err <= 1'b0;
      if (wd_expire)          tout_err <= 1'b1;
      else if (err_clr)       tout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ip_spi_seq.sv
// ---------------------------------------------------------------------------
// tb_ip_spi_seq
// Self-checking bench for ip_spi_seq with a behavioural ip_spi_m model.
// Inputs change 1 time unit after posedge; DUT outputs are observed on negedge.
// ---------------------------------------------------------------------------
module tb_ip_spi_seq;
  import ip_spi_seq_pkg::*;

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] data;
    logic [1:0]  fm;
    logic [3:0]  exp_cmd;
    logic [11:0] exp_data;
    logic [1:0]  exp_fm;
  } frame_vec_t;

  typedef struct {
    logic [7:0] gap;
    int         exp_low;
  } gap_vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, seq_start, seq_abort, err_clr;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_data;
  logic [1:0]  wr_fm;
  logic [7:0]  reg_gap;
  logic [3:0]  fifo_cnt;
  logic        fifo_full, fifo_empty, seq_busy, seq_done, ovf_err, tout_err;

  ip_spi_seq_if spi_if ();

  ip_spi_seq #(.DEPTH(8), .PTR_W(3), .TOUT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_cmd     (wr_cmd),
    .wr_data    (wr_data),
    .wr_fm      (wr_fm),
    .seq_start  (seq_start),
    .seq_abort  (seq_abort),
    .err_clr    (err_clr),
    .reg_gap    (reg_gap),
    .spi        (spi_if),
    .fifo_cnt   (fifo_cnt),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .ovf_err    (ovf_err),
    .tout_err   (tout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observation logs, cleared per test.
  int          rise_cyc [16];
  int          fall_cyc [16];
  int          n_rise, n_fall, done_cnt, done_cyc, start_cyc;
  logic [3:0]  fr_cmd  [16];
  logic [11:0] fr_data [16];
  logic [1:0]  fr_fm   [16];
  int          n_frames, done_drv_cyc;
  bit          fire_prev = 1'b0;

  // Master model controls.
  bit master_en  = 1'b1;
  int master_lat = 3;
  int m_cnt      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ip_spi_m model: after master_lat negedges of fire, pulse done for one cycle.
  initial begin
    spi_if.done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spi_if.done = 1'b0;
        m_cnt = 0;
      end else if (spi_if.done) begin
        spi_if.done = 1'b0;
        m_cnt = 0;
      end else if (spi_if.fire && master_en) begin
        m_cnt++;
        if (m_cnt >= master_lat) begin
          spi_if.done = 1'b1;
          done_drv_cyc = cyc;
          if (n_frames < 16) begin
            fr_cmd[n_frames]  = spi_if.cmd;
            fr_data[n_frames] = spi_if.data;
            fr_fm[n_frames]   = spi_if.data_fm;
          end
          n_frames++;
        end
      end else begin
        m_cnt = 0;
      end
    end
  end

  // Edge / pulse monitor.
  initial forever begin
    @(negedge clk);
    if (spi_if.fire && !fire_prev) begin
      if (n_rise < 16) rise_cyc[n_rise] = cyc;
      n_rise++;
    end
    if (!spi_if.fire && fire_prev) begin
      if (n_fall < 16) fall_cyc[n_fall] = cyc;
      n_fall++;
    end
    fire_prev = spi_if.fire;
    if (seq_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    n_rise = 0; n_fall = 0; done_cnt = 0; done_cyc = 0;
    n_frames = 0; done_drv_cyc = 0;
  endtask

  task automatic push(input logic [3:0] c, input logic [11:0] d, input logic [1:0] f);
    wr_en = 1'b1; wr_cmd = c; wr_data = d; wr_fm = f;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    seq_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    seq_start = 1'b0;
  endtask

  task automatic pulse_abort();
    seq_abort = 1'b1;
    @(posedge clk); #1;
    seq_abort = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic wait_seq_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("seq_done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int budget);
    int n = 0;
    while (n_rise == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("fire_rise_seen", 32'(n_rise != 0), 32'd1);
  endtask

  frame_vec_t fv [3];
  gap_vec_t   gv [5];

  initial begin
    fv[0] = '{4'h1, 12'h0AB, 2'd0, 4'h1, 12'h0AB, 2'd0};
    fv[1] = '{4'h2, 12'h155, 2'd1, 4'h2, 12'h155, 2'd1};
    fv[2] = '{4'h3, 12'hFFF, 2'd2, 4'h3, 12'hFFF, 2'd2};
    gv[0] = '{8'd10, 10};
    gv[1] = '{8'd0,  4};
    gv[2] = '{8'd3,  4};
    gv[3] = '{8'd4,  4};
    gv[4] = '{8'd5,  5};

    rst_n = 1'b0; wr_en = 1'b0; seq_start = 1'b0; seq_abort = 1'b0; err_clr = 1'b0;
    wr_cmd = '0; wr_data = '0; wr_fm = '0; reg_gap = 8'd10;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    check("rst_fire",  32'(spi_if.fire), 32'd0);
    check("rst_cmd",   32'(spi_if.cmd), 32'd0);
    check("rst_data",  32'(spi_if.data), 32'd0);
    check("rst_fm",    32'(spi_if.data_fm), 32'd0);
    check("rst_cnt",   32'(fifo_cnt), 32'd0);
    check("rst_full",  32'(fifo_full), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_busy",  32'(seq_busy), 32'd0);
    check("rst_done",  32'(seq_done), 32'd0);
    check("rst_ovf",   32'(ovf_err), 32'd0);
    check("rst_tout",  32'(tout_err), 32'd0);

    // Three frames in order with a 10-cycle gap.
    clear_logs();
    reg_gap = 8'd10;
    for (int i = 0; i < 3; i++) push(fv[i].cmd, fv[i].data, fv[i].fm);
    check("t1_cnt", 32'(fifo_cnt), 32'd3);
    pulse_start();
    wait_seq_done(300);
    check("t1_latency", 32'(rise_cyc[0] - start_cyc), 32'd2);
    check("t1_n_rise", 32'(n_rise), 32'd3);
    check("t1_n_frames", 32'(n_frames), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_cmd%0d", i),  32'(fr_cmd[i]),  32'(fv[i].exp_cmd));
      check($sformatf("t1_data%0d", i), 32'(fr_data[i]), 32'(fv[i].exp_data));
      check($sformatf("t1_fm%0d", i),   32'(fr_fm[i]),   32'(fv[i].exp_fm));
    end
    check("t1_gap0", 32'(rise_cyc[1] - fall_cyc[0]), 32'd10);
    check("t1_gap1", 32'(rise_cyc[2] - fall_cyc[1]), 32'd10);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_empty", 32'(fifo_empty), 32'd1);
    check("t1_busy", 32'(seq_busy), 32'd0);
    check("t1_cmd_held", 32'(spi_if.cmd), 32'd3);

    // Gap floor: fire low time between two frames for several reg_gap values.
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      reg_gap = gv[i].gap;
      push(4'h5, 12'h111, 2'd0);
      push(4'h6, 12'h222, 2'd1);
      pulse_start();
      wait_seq_done(200);
      check($sformatf("gap_rise_%0d", gv[i].gap), 32'(n_rise), 32'd2);
      check($sformatf("gap_low_%0d", gv[i].gap), 32'(rise_cyc[1] - fall_cyc[0]), 32'(gv[i].exp_low));
    end

    // Overflow: 9 writes into 8 entries.
    clear_logs();
    reg_gap = 8'd4;
    for (int i = 0; i < 9; i++) push(4'(i + 1), 12'h100 + 12'(i), 2'd0);
    check("ovf_cnt", 32'(fifo_cnt), 32'd8);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_err_set", 32'(ovf_err), 32'd1);
    wr_en = 1'b1; err_clr = 1'b1; wr_cmd = 4'hF;
    @(posedge clk); #1;
    wr_en = 1'b0; err_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_err), 32'd1);
    pulse_err_clr();
    check("ovf_err_clr", 32'(ovf_err), 32'd0);
    pulse_start();
    wait_seq_done(400);
    check("ovf_n_frames", 32'(n_frames), 32'd8);
    check("ovf_last_cmd", 32'(fr_cmd[7]), 32'd8);
    check("ovf_last_data", 32'(fr_data[7]), 32'h107);
    check("ovf_empty", 32'(fifo_empty), 32'd1);

    // Watchdog: master never answers.
    clear_logs();
    master_en = 1'b0;
    for (int i = 0; i < 3; i++) push(fv[i].cmd, fv[i].data, fv[i].fm);
    pulse_start();
    wait_seq_done(200);
    check("wd_fire_len", 32'(fall_cyc[0] - rise_cyc[0]), 32'd63);
    check("wd_tout_err", 32'(tout_err), 32'd1);
    check("wd_flushed", 32'(fifo_cnt), 32'd0);
    check("wd_n_rise", 32'(n_rise), 32'd1);
    check("wd_done_cnt", 32'(done_cnt), 32'd1);
    check("wd_done_cyc", 32'(done_cyc - rise_cyc[0]), 32'd64);
    pulse_err_clr();
    check("wd_err_clr", 32'(tout_err), 32'd0);
    master_en = 1'b1;

    // Abort during frame 1: frame completes, rest flushed.
    clear_logs();
    master_lat = 5;
    for (int i = 0; i < 3; i++) push(fv[i].cmd, fv[i].data, fv[i].fm);
    pulse_start();
    wait_rise(20);
    pulse_abort();
    wait_seq_done(100);
    check("ab_n_rise", 32'(n_rise), 32'd1);
    check("ab_n_frames", 32'(n_frames), 32'd1);
    check("ab_cmd", 32'(fr_cmd[0]), 32'd1);
    check("ab_cnt", 32'(fifo_cnt), 32'd0);
    check("ab_done_cnt", 32'(done_cnt), 32'd1);
    check("ab_fire_drop", 32'(fall_cyc[0] - done_drv_cyc), 32'd1);
    // seq_done is registered out of DONE, one cycle after done is sampled.
    check("ab_done_cyc", 32'(done_cyc - done_drv_cyc), 32'd2);
    master_lat = 3;

    // Writes while busy join the running sequence; start while busy ignored.
    clear_logs();
    push(4'hA, 12'h0A0, 2'd0);
    pulse_start();
    wait_rise(20);
    push(4'hB, 12'h0B0, 2'd1);
    pulse_start();
    wait_seq_done(200);
    repeat (5) @(posedge clk);
    #1;
    check("busy_n_frames", 32'(n_frames), 32'd2);
    check("busy_cmd1", 32'(fr_cmd[1]), 32'hB);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_idle", 32'(seq_busy), 32'd0);

    // Start with empty FIFO.
    clear_logs();
    pulse_start();
    wait_seq_done(20);
    check("empty_done_cyc", 32'(done_cyc - start_cyc), 32'd2);
    check("empty_no_fire", 32'(n_rise), 32'd0);

    // Reset in the middle of FIRE.
    clear_logs();
    master_en = 1'b0;
    push(4'h7, 12'h777, 2'd2);
    push(4'h8, 12'h888, 2'd2);
    pulse_start();
    wait_rise(20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fire", 32'(spi_if.fire), 32'd0);
    check("mid_rst_cmd", 32'(spi_if.cmd), 32'd0);
    check("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    check("mid_rst_empty", 32'(fifo_empty), 32'd1);
    check("mid_rst_busy", 32'(seq_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    master_en = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
